// File: rtl/uart_pkg.sv
// Shared types and constants for the serial UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // start + 8 data + stop
  localparam int FRAME_BITS = 10;

  // Clock cycles per bit, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/serial_uart_tx_if.sv
// Byte write handshake between the processor serial port and the UART transmitter.
interface serial_uart_tx_if;

  logic [7:0] data_in;
  logic       wren_in;
  logic       ready_out;

  modport master (
    output data_in,
    output wren_in,
    input  ready_out
  );

  modport slave (
    input  data_in,
    input  wren_in,
    output ready_out
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; pointers carry an extra MSB to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is data only; the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/serial_uart_tx.sv
// 8N1 UART transmitter fed by a small FIFO from the processor serial output port.
module serial_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  serial_uart_tx_if.slave               bus,
  output logic                          tx,
  output logic                          busy_out,
  output logic [$clog2(FIFO_DEPTH):0]   count_out,
  output logic                          overflow_out,
  input  logic                          overflow_clr
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int DIV_W = $clog2(DIV);

  tx_state_t        state;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_q;
  logic             div_term;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_rdata;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (bus.wren_in),
    .pop   (fifo_pop),
    .wdata (bus.data_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count_out)
  );

  assign bus.ready_out = !fifo_full;
  assign div_term      = (div_cnt == DIV_W'(DIV - 1));

  // Pop from IDLE, or at the end of STOP so frames run back to back.
  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty) begin
      fifo_pop = (state == IDLE) || ((state == STOP) && div_term);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      div_cnt  <= '0;
      bit_idx  <= '0;
      busy_out <= 1'b0;
    end else begin
      busy_out <= (state != IDLE) || !fifo_empty;
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          div_cnt <= '0;
          if (fifo_pop) state <= START;
        end
        START: begin
          tx <= 1'b0;
          if (div_term) begin
            div_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DATA: begin
          tx <= shift_q[0];
          if (div_term) begin
            div_cnt <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (div_term) begin
            div_cnt <= '0;
            state   <= fifo_pop ? START : IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift register holds payload only and needs no reset.
  always_ff @(posedge clock) begin
    if (fifo_pop) begin
      shift_q <= fifo_rdata;
    end else if ((state == DATA) && div_term) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_out <= 1'b0;
    end else if (overflow_clr) begin
      overflow_out <= 1'b0;
    end else if (bus.wren_in && fifo_full) begin
      overflow_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_uart_tx.sv
// Self-checking bench for serial_uart_tx: line decoder plus byte-queue reference model.
module tb_serial_uart_tx;

  localparam int CLK_HZ     = 1_000_000;
  localparam int BAUD       = 100_000;
  localparam int FIFO_DEPTH = 4;
  localparam int BITC       = 10;
  localparam int FRAMEC     = 100;

  logic       clock;
  logic       reset;
  logic       tx;
  logic       busy_out;
  logic [2:0] count_out;
  logic       overflow_out;
  logic       overflow_clr;

  serial_uart_tx_if bus ();

  serial_uart_tx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .tx           (tx),
    .busy_out     (busy_out),
    .count_out    (count_out),
    .overflow_out (overflow_out),
    .overflow_clr (overflow_clr)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] rx_q[$];
  int         start_q[$];
  logic [7:0] exp_q[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Expected line level k cycles after the write edge for a lone frame of byte b.
  function automatic logic exp_line(input logic [7:0] b, input int k);
    int j;
    int slot;
    if (k < 2) return 1'b1;
    j = k - 2;
    if (j >= FRAMEC) return 1'b1;
    slot = j / BITC;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot - 1];
  endfunction

  // Line decoder: samples mid-bit on negedges and queues decoded bytes.
  initial begin : decoder
    logic       prev;
    logic [7:0] b;
    bit         abort;
    int         t0;
    prev = 1'b1;
    forever begin
      @(negedge clock);
      if (!reset && prev && !tx) begin
        t0 = cyc;
        abort = 0;
        repeat (5) begin
          @(negedge clock);
          if (reset) abort = 1;
        end
        if (!abort) check_eq("start_bit", tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (BITC) begin
            @(negedge clock);
            if (reset) abort = 1;
          end
          b[i] = tx;
        end
        repeat (BITC) begin
          @(negedge clock);
          if (reset) abort = 1;
        end
        if (!abort) begin
          check_eq("stop_bit", tx, 1'b1);
          rx_q.push_back(b);
          start_q.push_back(t0);
        end
        prev = 1'b1;
      end else begin
        prev = tx;
      end
    end
  end

  task automatic wait_frames(input int n, input int budget);
    int waited;
    waited = 0;
    while (rx_q.size() < n && waited < budget) begin
      @(negedge clock);
      waited++;
    end
    if (rx_q.size() < n) check_eq("frame_timeout", rx_q.size(), n);
  endtask

  task automatic compare_rx(input string tag);
    check_eq({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check_eq({tag, "_byte"}, rx_q[i], exp_q[i]);
    end
  endtask

  task automatic clear_queues();
    rx_q.delete();
    start_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while (busy_out && waited < 3000) begin
      @(negedge clock);
      waited++;
    end
    check_eq("idle_reached", busy_out, 1'b0);
    repeat (3) @(negedge clock);
  endtask

  initial begin : main
    logic [7:0] b;
    int         sent;
    int         budget;
    int         max_count;
    bit         ovf_seen;
    int         lows;

    reset        = 1'b1;
    overflow_clr = 1'b0;
    bus.data_in  = '0;
    bus.wren_in  = 1'b0;

    repeat (3) @(negedge clock);
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_ready", bus.ready_out, 1'b1);
    check_eq("rst_busy", busy_out, 1'b0);
    check_eq("rst_count", count_out, 0);
    check_eq("rst_ovf", overflow_out, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Single byte with cycle-exact line and busy timing.
    clear_queues();
    @(negedge clock);
    bus.data_in = 8'h55;
    bus.wren_in = 1'b1;
    @(negedge clock);
    bus.wren_in = 1'b0;
    check_eq("single_count1", count_out, 1);
    for (int k = 1; k <= 105; k++) begin
      @(negedge clock);
      check_eq("single_tx", tx, exp_line(8'h55, k));
      check_eq("single_busy", busy_out, (k <= 101) ? 1'b1 : 1'b0);
    end
    check_eq("single_count0", count_out, 0);
    exp_q.push_back(8'h55);
    compare_rx("single");

    // Back-to-back frames with no gap.
    wait_idle();
    clear_queues();
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q = '{8'hA5, 8'h3C, 8'hFF};
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      bus.data_in = exp_q[i];
      bus.wren_in = 1'b1;
    end
    @(negedge clock);
    bus.wren_in = 1'b0;
    wait_frames(3, 500);
    compare_rx("b2b");
    if (start_q.size() >= 3) begin
      check_eq("b2b_gap1", start_q[1] - start_q[0], FRAMEC);
      check_eq("b2b_gap2", start_q[2] - start_q[1], FRAMEC);
    end

    // Back-pressure, overflow and clear priority.
    wait_idle();
    clear_queues();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      b = 8'($urandom);
      if (i == 5) check_eq("full_ready", bus.ready_out, 1'b0);
      else exp_q.push_back(b);
      bus.data_in = b;
      bus.wren_in = 1'b1;
    end
    @(negedge clock);
    bus.wren_in = 1'b0;
    check_eq("full_ovf_set", overflow_out, 1'b1);
    check_eq("full_count", count_out, 4);
    bus.data_in  = 8'hEE;
    bus.wren_in  = 1'b1;
    overflow_clr = 1'b1;
    @(negedge clock);
    bus.wren_in  = 1'b0;
    overflow_clr = 1'b0;
    check_eq("ovf_clr_coincident", overflow_out, 1'b0);
    bus.wren_in = 1'b1;
    @(negedge clock);
    bus.wren_in = 1'b0;
    check_eq("ovf_reset_again", overflow_out, 1'b1);
    overflow_clr = 1'b1;
    @(negedge clock);
    overflow_clr = 1'b0;
    check_eq("ovf_clr_pulse", overflow_out, 1'b0);
    wait_frames(5, 800);
    repeat (150) @(negedge clock);
    compare_rx("full");

    // Reset in the middle of a frame discards it and the queued byte.
    wait_idle();
    clear_queues();
    @(negedge clock);
    bus.data_in = 8'h0F;
    bus.wren_in = 1'b1;
    @(negedge clock);
    bus.data_in = 8'hF0;
    @(negedge clock);
    bus.wren_in = 1'b0;
    repeat (46) @(negedge clock);
    check_eq("midrst_count_before", count_out, 1);
    check_eq("midrst_busy_before", busy_out, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_tx", tx, 1'b1);
    check_eq("midrst_count", count_out, 0);
    check_eq("midrst_busy", busy_out, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    lows = 0;
    for (int k = 0; k < 250; k++) begin
      @(negedge clock);
      if (!tx) lows++;
    end
    check_eq("midrst_no_lows", lows, 0);
    check_eq("midrst_no_frames", rx_q.size(), 0);
    check_eq("midrst_ovf", overflow_out, 1'b0);

    // Random stream through the pointer wrap, writing only when ready.
    clear_queues();
    sent = 0;
    budget = 0;
    max_count = 0;
    ovf_seen = 0;
    while (rx_q.size() < 20 && budget < 5000) begin
      @(negedge clock);
      budget++;
      bus.wren_in = 1'b0;
      if (int'(count_out) > max_count) max_count = int'(count_out);
      if (overflow_out) ovf_seen = 1;
      if (sent < 20 && bus.ready_out && $urandom_range(0, 3) != 0) begin
        b = 8'($urandom);
        bus.data_in = b;
        bus.wren_in = 1'b1;
        exp_q.push_back(b);
        sent++;
      end
    end
    bus.wren_in = 1'b0;
    check_eq("rand_sent", sent, 20);
    compare_rx("rand");
    check_eq("rand_max_count_ok", (max_count <= FIFO_DEPTH), 1'b1);
    check_eq("rand_ovf", ovf_seen, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_uart_tx.md
Name: serial_uart_tx

Overview:
- Transmit-side serial stage. Sits directly downstream of the processor's serial output port (serial_out / serial_wren_out / serial_ready_in) in the DE1-SoC top level.
- Buffers bytes written by the CPU in a small FIFO and serialises them as 8N1 UART frames on a GPIO pin.
- Returns back-pressure to the CPU via ready_out.
- Exposes occupancy and sticky-overflow status for LEDs/HEX debug.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz.
- BAUD, 115200, line rate. DIV = (CLK_HZ + BAUD/2) / BAUD clock cycles per bit (434 at the defaults). DIV must be at least 2.
- FIFO_DEPTH, 16, FIFO entries. Must be a power of 2, at least 2.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-high reset.
- data_in  in  8  byte from the processor serial_out.
- wren_in  in  1  single-cycle write strobe from serial_wren_out.
- ready_out  out  1  high when the FIFO is not full. Drives the processor serial_ready_in.
- tx  out  1  UART line; idles high.
- busy_out  out  1  high while a frame is on the line or the FIFO is non-empty.
- count_out  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow_out  out  1  sticky; set when a write arrives while full.
- overflow_clr  in  1  synchronous clear of overflow_out.

Behaviour:
- Reset (async assert, sync release):
  - tx=1, state=IDLE, FIFO empty, count_out=0.
  - ready_out=1, busy_out=0, overflow_out=0.
  - Divider and bit counter are zero.
- Reset asserted mid-frame aborts immediately: tx forced to 1, FIFO contents discarded.
- FIFO write:
  - On a clock edge with wren_in=1 and full=0, data_in is stored.
  - ready_out = !full, combinational from the registered count.
  - A write while full is dropped and sets overflow_out. This holds even if a pop occurs in the same cycle, because full is evaluated before the edge.
- Simultaneous push and pop when neither full nor empty: count is unchanged, and both pointers advance modulo FIFO_DEPTH. Pointers wrap naturally and carry an extra MSB to distinguish full from empty.
- overflow_clr has priority over a set in the same cycle.
- Transmitter FSM (all outputs registered):
  - IDLE: tx=1. If the FIFO is non-empty: pop the head into an 8-bit shift register, go to START, and clear the divider.
  - START: tx=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] (LSB first) for DIV cycles per bit. Shift right after each bit. After bit 7, go to STOP.
  - STOP: tx=1 for DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap between frames); otherwise go to IDLE.
- Latency: a wren_in sampled at edge N into an empty FIFO with the FSM in IDLE makes tx fall at edge N+2 (FIFO write at N, pop/state change at N+1, registered tx at N+2).
- A frame occupies exactly 10*DIV cycles on the line.
- Divider: counter 0..DIV-1. Its terminal count advances the bit or state. Width is $clog2(DIV).
- busy_out = (state != IDLE) || !empty. It drops in the first cycle the FSM is back in IDLE with the FIFO empty.
- A push to an empty FIFO while the FSM is in STOP's final cycle is not visible for that cycle's pop decision. The FSM goes to IDLE and pops on the next cycle; this is legal.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP);
  - a function computing DIV from CLK_HZ and BAUD;
  - the frame length constant (10 bits).
- One sub-module, sync_fifo: parameterised width/depth; outputs full, empty and count; async active-high reset.
- serial_uart_tx contains the FSM, divider and shift register.

Test Plan (sim with CLK_HZ=1_000_000, BAUD=100_000, so DIV=10; FIFO_DEPTH=4):
- Single byte: reset, then write 0x55 at edge N. Expect tx low from N+2 for 10 cycles, then data bits 1,0,1,0,1,0,1,0 for 10 cycles each, then high for 10 cycles. busy_out drops at N+102; count_out returns to 0.
- Back-to-back: write 0xA5, 0x3C, 0xFF on consecutive cycles. Expect three contiguous frames of 100 cycles each with no idle cycles between them. The decoded bytes must match in order.
- Full/back-pressure: write 6 bytes in consecutive cycles while idle. The first pops at the next edge, so 5 are accepted and the sixth is dropped. Expect ready_out=0 at the sixth write, overflow_out=1, and exactly 5 frames on tx.
- Overflow clear: with overflow_out=1, pulse overflow_clr for 1 cycle. Expect overflow_out=0 next edge; a clear coincident with an overflowing write also yields 0.
- Reset mid-frame: assert reset during DATA bit 3 of 0x0F. Expect tx=1 and count_out=0 asynchronously. After release, no residual frame appears and tx stays high.
- Pointer wrap: stream 20 random bytes, each written when ready_out=1. Expect all 20 received in order, count_out never exceeding 4, and overflow_out never set.
